// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register file write-port arbiter and long-latency scoreboard
// Optional same-cycle busy clear on B handshake: RF_WB_SB_BYPASS_EN
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_a_wen,
  input  logic [4:0]  i_a_waddr,
  input  logic [31:0] i_a_wdata,
  output logic        o_wb_stall,
  input  logic        i_b_valid,
  input  logic [4:0]  i_b_waddr,
  input  logic [31:0] i_b_wdata,
  output logic        o_b_ready,
  input  logic        i_iss_valid,
  input  logic [4:0]  i_iss_rd,
  output logic        o_iss_ready,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic        o_rs1_busy,
  output logic        o_rs2_busy,
  output logic        o_rd_wen,
  output logic [4:0]  o_rd_waddr,
  output logic [31:0] o_rd_wdata
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]  wait_cnt;
  logic [31:0] busy;
  logic [31:0] busy_view;
  logic [31:0] clr_vec;
  logic [31:0] set_vec;
  logic        a_active;
  logic        guard;
  logic        grant_a;
  logic        grant_b;
  logic        iss_ok;

  always_comb begin
    a_active = i_a_wen && (i_a_waddr != 5'd0);
    guard    = i_b_valid && (wait_cnt == LIMIT);
    grant_b  = guard || (i_b_valid && !a_active);
    grant_a  = a_active && !guard;
    clr_vec  = grant_b ? (32'd1 << i_b_waddr) : 32'd0;
`ifdef RF_WB_SB_BYPASS_EN
    busy_view = busy & ~clr_vec;
`else
    busy_view = busy;
`endif
    iss_ok  = (i_iss_rd == 5'd0) || !busy_view[i_iss_rd];
    set_vec = (i_iss_valid && iss_ok && (i_iss_rd != 5'd0)) ? (32'd1 << i_iss_rd) : 32'd0;
  end

  // Reset forces the hazard-facing outputs to their idle values immediately.
  always_comb begin
    o_b_ready   = grant_b;
    o_wb_stall  = !i_rst && guard;
    o_iss_ready = i_rst || iss_ok;
    o_rs1_busy  = !i_rst && busy_view[i_rs1_addr];
    o_rs2_busy  = !i_rst && busy_view[i_rs2_addr];
    o_rd_wen    = !i_rst && (grant_a || (grant_b && (i_b_waddr != 5'd0)));
    o_rd_waddr  = grant_a ? i_a_waddr : i_b_waddr;
    o_rd_wdata  = grant_a ? i_a_wdata : i_b_wdata;
  end

  // Set is applied after clear so a re-issue to the returning register stays busy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy     <= 32'd0;
      wait_cnt <= 8'd0;
    end else begin
      busy <= ((busy & ~clr_vec) | set_vec) & ~32'd1;
      if (!i_b_valid || grant_b)
        wait_cnt <= 8'd0;
      else if (wait_cnt != LIMIT)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed and randomized check of rf_wb_arbiter against a reference model
module tb_rf_wb_arbiter;
  localparam int LIMIT = 4;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_a_wen = 1'b0;
  logic [4:0]  i_a_waddr = '0;
  logic [31:0] i_a_wdata = '0;
  logic        o_wb_stall;
  logic        i_b_valid = 1'b0;
  logic [4:0]  i_b_waddr = '0;
  logic [31:0] i_b_wdata = '0;
  logic        o_b_ready;
  logic        i_iss_valid = 1'b0;
  logic [4:0]  i_iss_rd = '0;
  logic        o_iss_ready;
  logic [4:0]  i_rs1_addr = '0;
  logic [4:0]  i_rs2_addr = '0;
  logic        o_rs1_busy;
  logic        o_rs2_busy;
  logic        o_rd_wen;
  logic [4:0]  o_rd_waddr;
  logic [31:0] o_rd_wdata;

  rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_a_wen(i_a_wen), .i_a_waddr(i_a_waddr), .i_a_wdata(i_a_wdata), .o_wb_stall(o_wb_stall),
    .i_b_valid(i_b_valid), .i_b_waddr(i_b_waddr), .i_b_wdata(i_b_wdata), .o_b_ready(o_b_ready),
    .i_iss_valid(i_iss_valid), .i_iss_rd(i_iss_rd), .o_iss_ready(o_iss_ready),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr), .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy),
    .o_rd_wen(o_rd_wen), .o_rd_waddr(o_rd_waddr), .o_rd_wdata(o_rd_wdata)
  );

  always #5 i_clk = ~i_clk;

`ifdef RF_WB_SB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  bit pend[32];
  int starve = 0;
  bit last_hs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit seen_busy(input int r, input bit hs);
    return pend[r] && !(BYPASS && hs && r == int'(i_b_waddr));
  endfunction

  // One clock: predict outputs from the current inputs, check, then advance the model.
  task automatic step();
    bit a_act, starved, take_b, take_a, exp_iss;
    #2;
    a_act   = i_a_wen && i_a_waddr != 0;
    starved = i_b_valid && starve == LIMIT;
    take_b  = starved || (i_b_valid && !a_act);
    take_a  = a_act && !starved;
    exp_iss = 1'b1;
    if (i_rst) begin
      chk("rst_rd_wen", o_rd_wen, 0);
      chk("rst_stall", o_wb_stall, 0);
      chk("rst_iss_ready", o_iss_ready, 1);
      chk("rst_rs1_busy", o_rs1_busy, 0);
      chk("rst_rs2_busy", o_rs2_busy, 0);
    end else begin
      chk("upstream_a_not_busy", a_act && pend[i_a_waddr], 0);
      chk("upstream_b_is_busy", i_b_valid && i_b_waddr != 0 && !pend[i_b_waddr], 0);
      exp_iss = (i_iss_rd == 0) || !seen_busy(i_iss_rd, take_b);
      chk("b_ready", o_b_ready, take_b);
      chk("stall", o_wb_stall, starved);
      chk("rd_wen", o_rd_wen, take_a || (take_b && i_b_waddr != 0));
      if (take_a) begin
        chk("rd_waddr_a", o_rd_waddr, i_a_waddr);
        chk("rd_wdata_a", o_rd_wdata, i_a_wdata);
      end else if (take_b && i_b_waddr != 0) begin
        chk("rd_waddr_b", o_rd_waddr, i_b_waddr);
        chk("rd_wdata_b", o_rd_wdata, i_b_wdata);
      end
      chk("iss_ready", o_iss_ready, exp_iss);
      chk("rs1_busy", o_rs1_busy, seen_busy(i_rs1_addr, take_b));
      chk("rs2_busy", o_rs2_busy, seen_busy(i_rs2_addr, take_b));
    end
    @(posedge i_clk);
    last_hs = !i_rst && take_b;
    if (i_rst) begin
      foreach (pend[k]) pend[k] = 1'b0;
      starve = 0;
    end else begin
      if (take_b) pend[i_b_waddr] = 1'b0;
      if (i_iss_valid && exp_iss && i_iss_rd != 0) pend[i_iss_rd] = 1'b1;
      pend[0] = 1'b0;
      if (!i_b_valid || take_b) starve = 0;
      else if (starve < LIMIT) starve++;
    end
    #1;
  endtask

  initial begin
    int pick;
    int plist[$];
    // reset, then reset again with a register busy
    step(); step();
    i_rst = 0;
    i_iss_valid = 1; i_iss_rd = 3; step();
    i_iss_valid = 0; i_rs1_addr = 3; step();
    chk("busy_before_rst", o_rs1_busy, 1);
    i_rst = 1; i_iss_rd = 3; step();
    i_rst = 0; step();
    chk("busy_after_rst", o_rs1_busy, 0);

    // A wins over B, B granted when A idles
    i_iss_valid = 1; i_iss_rd = 7; step();
    i_iss_valid = 0;
    i_a_wen = 1; i_a_waddr = 5; i_a_wdata = 32'h11;
    i_b_valid = 1; i_b_waddr = 7; i_b_wdata = 32'h77; i_rs1_addr = 7;
    step();
    i_a_wen = 0; #2;
    chk("b_ready_a_idle", o_b_ready, 1);
    chk("rd_waddr_b7", o_rd_waddr, 7);
    step();
    i_b_valid = 0; #2;
    chk("x7_cleared", o_rs1_busy, 0);
    step();

    // starvation guard on the 5th cycle of continuous A traffic
    i_iss_valid = 1; i_iss_rd = 7; step();
    i_iss_valid = 0;
    i_b_valid = 1; i_b_waddr = 7; i_b_wdata = 32'hbeef;
    for (int k = 0; k < LIMIT + 1; k++) begin
      i_a_wen = 1; i_a_waddr = 5'(10 + k); i_a_wdata = 32'(k);
      #2;
      chk("starve_stall", o_wb_stall, (k == LIMIT));
      step();
    end
    i_b_valid = 0; i_a_wen = 0; step();

    // issue to x9 blocks reissue until x9 returns
    i_iss_valid = 1; i_iss_rd = 9; step();
    i_rs1_addr = 9;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("x9_iss_blocked", o_iss_ready, 0);
      chk("x9_rs1_busy", o_rs1_busy, 1);
      step();
    end
    i_iss_valid = 0; i_b_valid = 1; i_b_waddr = 9; i_rs2_addr = 9; #2;
    chk("x9_rs2_on_hs", o_rs2_busy, !BYPASS);
    step();
    i_b_valid = 0; step();

    // rd = 0 issue and x0 return
    i_iss_valid = 1; i_iss_rd = 0; i_rs1_addr = 0; step();
    i_iss_valid = 0; i_b_valid = 1; i_b_waddr = 0; #2;
    chk("x0_rd_wen", o_rd_wen, 0);
    chk("x0_b_ready", o_b_ready, 1);
    step();
    i_b_valid = 0; step();

    // randomized traffic obeying the upstream rules
    for (int n = 0; n < 800; n++) begin
      if (i_b_valid && last_hs) i_b_valid = 0;
      i_rst = ($urandom_range(0, 99) == 0);
      if (i_rst) i_b_valid = 0;
      i_a_wen = ($urandom_range(0, 9) < 6);
      do pick = $urandom_range(0, 31); while (pend[pick]);
      i_a_waddr = 5'(pick); i_a_wdata = $urandom;
      if (!i_b_valid && !i_rst && $urandom_range(0, 9) < 4) begin
        plist.delete();
        foreach (pend[k]) if (pend[k]) plist.push_back(k);
        if (plist.size() > 0) begin
          i_b_valid = 1; i_b_waddr = 5'(plist[$urandom_range(0, plist.size() - 1)]);
          i_b_wdata = $urandom;
        end else if ($urandom_range(0, 3) == 0) begin
          i_b_valid = 1; i_b_waddr = 0; i_b_wdata = $urandom;
        end
      end
      i_iss_valid = ($urandom_range(0, 9) < 3);
      i_iss_rd = 5'($urandom_range(0, 31));
      i_rs1_addr = $urandom_range(0, 1) ? i_b_waddr : 5'($urandom_range(0, 31));
      i_rs2_addr = $urandom_range(0, 1) ? i_b_waddr : 5'($urandom_range(0, 31));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
